// File: rtl/pwm_pkg.sv
// Shared types and default widths for the PWM fader and its prescaler.
package pwm_pkg;

  localparam int PWM_N     = 8;
  localparam int PWM_DIV_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } fader_state_t;

endpackage

// File: rtl/step_prescaler.sv
// Clock prescaler: registered one-cycle step pulse every divider+1 enabled clocks.
module step_prescaler #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [DIV_W-1:0] divider,
  output logic             step
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             step_q, step_d;

  // Equality compare: a new divider is picked up at the next compare only.
  always_comb begin
    cnt_d  = cnt_q;
    step_d = 1'b0;
    if (ena) begin
      if (cnt_q == divider) begin
        cnt_d  = '0;
        step_d = 1'b1;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      step_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      step_q <= step_d;
    end
  end

  assign step = step_q;

endmodule

// File: rtl/pwm_fader.sv
// Duty ramp generator: moves duty toward a loaded target by stride, only at PWM period boundaries.
module pwm_fader
  import pwm_pkg::*;
#(
  parameter int N     = PWM_N,
  parameter int DIV_W = PWM_DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [DIV_W-1:0] divider,
  input  logic             load,
  input  logic [N-1:0]     target,
  input  logic [N-1:0]     stride,
  output logic             step,
  output logic [N-1:0]     duty,
  output logic             busy,
  output logic             done
);

  fader_state_t state_q, state_d;
  logic [N-1:0] per_q, per_d;
  logic [N-1:0] duty_q, duty_d;
  logic [N-1:0] tgt_q, tgt_d;
  logic [N-1:0] str_q, str_d;
  logic         done_q, done_d;
  logic [N-1:0] diff;
  logic         step_w;
  logic         ramp_tick;

  step_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .divider (divider),
    .step    (step_w)
  );

  // Period counter mirrors the downstream PWM counter; the last step of a period is the tick.
  assign ramp_tick = step_w & (per_q == '1);

  always_comb begin
    state_d = state_q;
    per_d   = step_w ? per_q + N'(1) : per_q;
    duty_d  = duty_q;
    tgt_d   = tgt_q;
    str_d   = str_q;
    done_d  = 1'b0;
    diff    = '0;
    if (load) begin
      tgt_d = target;
      str_d = stride;
      if (target > duty_q) begin
        state_d = UP;
      end else if (target < duty_q) begin
        state_d = DOWN;
      end else begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end else if (ramp_tick) begin
      // Distance is taken in the known direction, so the final step clamps to target.
      case (state_q)
        UP: begin
          diff = tgt_q - duty_q;
          if (diff <= str_q) begin
            duty_d  = tgt_q;
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            duty_d = duty_q + str_q;
          end
        end
        DOWN: begin
          diff = duty_q - tgt_q;
          if (diff <= str_q) begin
            duty_d  = tgt_q;
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            duty_d = duty_q - str_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      per_q   <= '0;
      duty_q  <= '0;
      tgt_q   <= '0;
      str_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      per_q   <= per_d;
      duty_q  <= duty_d;
      tgt_q   <= tgt_d;
      str_q   <= str_d;
      done_q  <= done_d;
    end
  end

  assign step = step_w;
  assign duty = duty_q;
  assign busy = (state_q != IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_pwm_fader.sv
// Self-checking bench for pwm_fader: duty/done scoreboard plus directed prescaler and edge-load checks.
module tb_pwm_fader;

  localparam int N     = 8;
  localparam int DIV_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             ena;
  logic [DIV_W-1:0] divider;
  logic             load;
  logic [N-1:0]     target;
  logic [N-1:0]     stride;
  logic             step;
  logic [N-1:0]     duty;
  logic             busy;
  logic             done;

  // clock / reset
  always #5 clk = ~clk;

  pwm_fader #(.N(N), .DIV_W(DIV_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .divider (divider),
    .load    (load),
    .target  (target),
    .stride  (stride),
    .step    (step),
    .duty    (duty),
    .busy    (busy),
    .done    (done)
  );

  // scoreboard
  logic [N-1:0] exp_q[$];
  logic [N-1:0] done_q[$];
  int           n_chk = 0;
  int           n_pass = 0;
  int           step_cnt = 0;
  logic [N-1:0] last_duty = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Monitor: every duty change pops the next expected value and must land on a period boundary.
  always @(negedge clk) begin
    if (rst) begin
      step_cnt  = 0;
      last_duty = '0;
    end else begin
      if (duty != last_duty) begin
        if (exp_q.size() == 0) begin
          check_eq("duty_unexpected", 32'(duty), 32'(last_duty));
        end else begin
          check_eq("duty_value", 32'(duty), 32'(exp_q.pop_front()));
          check_eq("duty_boundary", step_cnt % 256, 0);
        end
        last_duty = duty;
      end
      if (done) begin
        if (done_q.size() == 0) begin
          check_eq("done_unexpected", 32'(done), 0);
        end else begin
          check_eq("done_duty", 32'(duty), 32'(done_q.pop_front()));
          check_eq("done_busy", 32'(busy), 0);
        end
      end
      if (step) step_cnt++;
    end
  end

  // driver tasks
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && done_q.size() == 0) break;
      cycle();
    end
    check_eq(tag, 32'(exp_q.size() + done_q.size()), 0);
  endtask

  task automatic count_steps(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      cycle();
      if (step) cnt++;
    end
  endtask

  task automatic do_load(input logic [N-1:0] t, input logic [N-1:0] s);
    target = t;
    stride = s;
    load   = 1'b1;
    cycle();
    load   = 1'b0;
  endtask

  initial begin
    int cnt;
    int k;
    int s0;
    bit found;

    rst = 1'b1; ena = 1'b1; load = 1'b0; divider = '0; target = '0; stride = '0;

    // reset behaviour
    for (int c = 0; c < 2; c++) begin
      cycle();
      check_eq("rst_step", 32'(step), 0);
      check_eq("rst_duty", 32'(duty), 0);
      check_eq("rst_busy", 32'(busy), 0);
      check_eq("rst_done", 32'(done), 0);
    end
    rst = 1'b0;
    cycle();
    check_eq("post_rst_duty", 32'(duty), 0);
    check_eq("post_rst_busy", 32'(busy), 0);
    check_eq("post_rst_done", 32'(done), 0);

    // prescaler: divider=3, hold with ena=0, divider=0
    divider = 16'd3;
    repeat (4) cycle();
    count_steps(40, cnt);
    check_eq("div3_steps", cnt, 10);
    k = 0;
    while (!step && k < 20) begin cycle(); k++; end
    check_eq("div3_sync", 32'(step), 1);
    repeat (2) cycle();
    ena = 1'b0;
    count_steps(20, cnt);
    check_eq("ena0_steps", cnt, 0);
    ena = 1'b1;
    k = 0;
    do begin cycle(); k++; end while (!step && k < 20);
    check_eq("ena_hold_latency", k, 2);
    divider = '0;
    count_steps(20, cnt);
    check_eq("div0_steps", cnt, 20);

    // ramp up 0 -> 10 by 4
    exp_q.push_back(8'd4); exp_q.push_back(8'd8); exp_q.push_back(8'd10);
    done_q.push_back(8'd10);
    do_load(8'd10, 8'd4);
    check_eq("t3_busy", 32'(busy), 1);
    drain(1200, "t3_drain");

    // ramp down 10 -> 0 by 3
    exp_q.push_back(8'd7); exp_q.push_back(8'd4); exp_q.push_back(8'd1); exp_q.push_back(8'd0);
    done_q.push_back(8'd0);
    do_load(8'd0, 8'd3);
    check_eq("t4_busy", 32'(busy), 1);
    drain(1400, "t4_drain");

    // mid-ramp freeze with ena=0
    exp_q.push_back(8'd50); exp_q.push_back(8'd100); exp_q.push_back(8'd150); exp_q.push_back(8'd200);
    done_q.push_back(8'd200);
    do_load(8'd200, 8'd50);
    check_eq("t5_busy", 32'(busy), 1);
    k = 0;
    while (exp_q.size() > 3 && k < 600) begin cycle(); k++; end
    check_eq("t5_reach50", 32'(exp_q.size()), 3);
    ena = 1'b0;
    cycle();
    s0 = step_cnt;
    repeat (1000) cycle();
    check_eq("t5_frozen_steps", step_cnt - s0, 0);
    check_eq("t5_frozen_duty", 32'(duty), 50);
    check_eq("t5_frozen_busy", 32'(busy), 1);
    ena = 1'b1;
    drain(1200, "t5_drain");

    // load with target equal to duty
    done_q.push_back(8'd200);
    do_load(8'd200, 8'd5);
    check_eq("t6a_done", 32'(done), 1);
    check_eq("t6a_busy", 32'(busy), 0);

    // stride zero freezes the ramp
    do_load(8'd255, 8'd0);
    check_eq("t6b_busy", 32'(busy), 1);
    repeat (600) cycle();
    check_eq("t6b_duty", 32'(duty), 200);
    check_eq("t6b_busy_hold", 32'(busy), 1);

    // retarget exactly on a ramp tick: tick discarded, ramp heads down from 220
    exp_q.push_back(8'd220);
    do_load(8'd255, 8'd20);
    k = 0;
    while (exp_q.size() > 0 && k < 600) begin cycle(); k++; end
    check_eq("t6c_reach220", 32'(exp_q.size()), 0);
    found = 1'b0;
    for (int i = 0; i < 600; i++) begin
      cycle();
      if (step && (step_cnt % 256) == 255) begin found = 1'b1; break; end
    end
    check_eq("t6c_tick_found", 32'(found), 1);
    exp_q.push_back(8'd160); exp_q.push_back(8'd100); exp_q.push_back(8'd40); exp_q.push_back(8'd0);
    done_q.push_back(8'd0);
    do_load(8'd0, 8'd60);
    check_eq("t6c_busy", 32'(busy), 1);
    check_eq("t6c_duty_held", 32'(duty), 220);
    drain(1400, "t6c_drain");

    // final report
    repeat (2) cycle();
    check_eq("final_queues", 32'(exp_q.size() + done_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
